mux_bus_arbiter_2x1_8bit: RTL and testbench
===========================================

Name: mux_bus_arbiter_2x1_8bit

Overview:
Round-robin arbiter that shares one 8-bit 2x1 mux path (select S, output Y) between two requesters feeding the processor's shared write-back bus. It owns the mux select, issues one-hot grants, registers the selected data with a valid flag, and caps how long one requester can hold the bus while the other waits. It sits between the requesting units (e.g. ALU result and memory read data) and the register-file write port.

Parameters:
WIDTH, 8, data width of D0/D1/Y
MAX_HOLD, 4, max consecutive granted cycles for one owner while the other requests (legal range >= 1)

Ports:
CLK  input  1  clock, rising-edge
RESETN  input  1  asynchronous active-low reset
REQ0  input  1  request from requester 0; held high for as long as it wants the bus
REQ1  input  1  request from requester 1
D0  input  WIDTH  data from requester 0
D1  input  WIDTH  data from requester 1
GNT0  output  1  grant to requester 0 (registered)
GNT1  output  1  grant to requester 1 (registered)
S  output  1  mux select: 0 = D0, 1 = D1 (registered)
Y  output  WIDTH  registered bus data
VALID  output  1  Y holds a new transfer this cycle
BUSY  output  1  high when state is not IDLE

Behaviour:
- Reset (RESETN=0, async, takes effect without a clock edge): state=IDLE, GNT0=GNT1=0, S=0, Y=0, VALID=0, hold_cnt=0, last_owner=1 (so requester 0 wins the first tie).
- States: IDLE, OWN0, OWN1. GNTx=1 exactly in OWNx. GNT0 and GNT1 are never both high. BUSY = (state != IDLE).
- S = owner index in OWNx. In IDLE, S holds its last value.
- IDLE: only REQ0 -> OWN0; only REQ1 -> OWN1; both high -> OWN of requester != last_owner; neither high -> stay IDLE.
- Grant latency: one cycle. REQ is sampled at an edge and GNT is high after that edge.
- Transfer cycle: a cycle with GNTx=1 and REQx=1. At the closing edge, Y <= Dx and VALID <= 1. Otherwise VALID <= 0 and Y holds.
- VALID/Y therefore lag the transfer cycle by exactly one cycle.
- OWNx exit rules, evaluated at each edge:
  - REQx=0: go to OWN(other) if the other requests, else IDLE. There is no bubble cycle on a direct handover.
  - REQx=1, other requesting, hold_cnt == MAX_HOLD-1: preempt to OWN(other).
  - Otherwise stay in OWNx.
- hold_cnt:
  - cleared on every entry to an OWN state (including OWNx -> OWN(other)).
  - increments on each transfer cycle and saturates at MAX_HOLD-1.
  - With no competing request, the owner keeps the grant indefinitely.
- last_owner is updated to x on every entry to OWNx.
- MAX_HOLD=1 with both requesting: grant alternates every cycle.
- A requester dropping REQ while granted gives no transfer that cycle. It re-arbitrates at the next edge like a fresh request.
- Dx changing mid-grant: every transfer cycle captures the current Dx value.
- hold_cnt width is the minimum needed to hold MAX_HOLD-1 (at least 1 bit).

Test Plan:
1. RESETN=0 with REQ0=1, D0=10 -> all outputs 0. Release, REQ0 held -> GNT0=1,S=0 after edge 1; VALID=1,Y=10 after edge 2 and stays so while REQ0 held.
2. From reset, REQ0=REQ1=1, D0=10, D1=20, MAX_HOLD=4 -> GNT0 for 4 cycles then GNT1 for 4 cycles, repeating. Y shows 10 x4, 20 x4 (lagging one cycle). VALID is never low; no cycle has both grants low.
3. REQ0 alone granted, then REQ0 drops -> next edge GNT0=0, BUSY=0, state IDLE. VALID=0 from the edge after the last transfer. S stays 0.
4. OWN1 active with REQ0 pending; REQ1 drops -> GNT0=1, S=0 at the very next edge (no idle cycle). The next tie after both re-request goes to requester 1.
5. Mid-grant (OWN1, VALID=1, Y=20): pulse RESETN low between edges -> GNT1, S, Y, VALID clear immediately. After release with both requesting, GNT0 wins.
6. OWN0 with D0=10, change D0 to 4 mid-grant -> Y=4 exactly one cycle after the change; with MAX_HOLD=1 and both requesting, GNT alternates 0,1,0,1 each cycle.

Source files
------------

// File: rtl/mux_bus_arbiter_2x1_8bit.sv
// Two-requester round-robin arbiter driving a registered 2:1 write-back mux.
// Caps consecutive ownership at MAX_HOLD transfer cycles while the other side waits.
module mux_bus_arbiter_2x1_8bit #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             VALID,
  output logic             BUSY
);

  localparam int unsigned    HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  state_e           other_st;
  logic [HCW-1:0]   hold_q, hold_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic owner;
  logic req_own;
  logic req_oth;
  logic xfer;
  logic cap;
  logic enter;

  always_comb begin
    owner    = (state_q == OWN1);
    req_own  = owner ? REQ1 : REQ0;
    req_oth  = owner ? REQ0 : REQ1;
    other_st = owner ? OWN0 : OWN1;
    xfer     = (state_q != IDLE) && req_own;
    cap      = (hold_q == HOLD_LAST);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // last_q == 1 means requester 1 was served last, so 0 wins a tie
        if (REQ0 && REQ1) state_d = last_q ? OWN0 : OWN1;
        else if (REQ0)    state_d = OWN0;
        else if (REQ1)    state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!req_own)            state_d = req_oth ? other_st : IDLE;
        else if (req_oth && cap) state_d = other_st;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enter   = (state_d != IDLE) && (state_d != state_q);
    hold_d  = hold_q;
    last_d  = last_q;
    sel_d   = sel_q;
    valid_d = xfer;
    y_d     = y_q;
    if (enter) begin
      hold_d = '0;
      last_d = (state_d == OWN1);
      sel_d  = (state_d == OWN1);
    end else if (xfer && !cap) begin
      hold_d = hold_q + 1'b1;
    end
    if (xfer) y_d = owner ? D1 : D0;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      y_q     <= y_d;
    end
  end

  assign GNT0  = (state_q == OWN0);
  assign GNT1  = (state_q == OWN1);
  assign BUSY  = (state_q != IDLE);
  assign S     = sel_q;
  assign Y     = y_q;
  assign VALID = valid_q;

  a_grant_onehot: assert property (@(posedge CLK) disable iff (!RESETN) !(GNT0 && GNT1));

endmodule

// File: tb/tb_mux_bus_arbiter_2x1_8bit.sv
// Bench for mux_bus_arbiter_2x1_8bit: MAX_HOLD=4 and MAX_HOLD=1 instances share stimulus
// and are compared each cycle against a rule-level ownership model plus directed expectations.
module tb_mux_bus_arbiter_2x1_8bit;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic       REQ0 = 1'b0;
  logic       REQ1 = 1'b0;
  logic [7:0] D0 = '0;
  logic [7:0] D1 = '0;

  logic       A_GNT0, A_GNT1, A_S, A_VALID, A_BUSY;
  logic [7:0] A_Y;
  logic       B_GNT0, B_GNT1, B_S, B_VALID, B_BUSY;
  logic [7:0] B_Y;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mux_bus_arbiter_2x1_8bit #(.WIDTH(8), .MAX_HOLD(4)) dut_a (
    .CLK(CLK), .RESETN(RESETN), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
    .GNT0(A_GNT0), .GNT1(A_GNT1), .S(A_S), .Y(A_Y), .VALID(A_VALID), .BUSY(A_BUSY)
  );

  mux_bus_arbiter_2x1_8bit #(.WIDTH(8), .MAX_HOLD(1)) dut_b (
    .CLK(CLK), .RESETN(RESETN), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
    .GNT0(B_GNT0), .GNT1(B_GNT1), .S(B_S), .Y(B_Y), .VALID(B_VALID), .BUSY(B_BUSY)
  );

  // observed vector layout: {GNT0, GNT1, S, BUSY, VALID, Y}
  logic [12:0] obs_a, obs_b;
  assign obs_a = {A_GNT0, A_GNT1, A_S, A_BUSY, A_VALID, A_Y};
  assign obs_b = {B_GNT0, B_GNT1, B_S, B_BUSY, B_VALID, B_Y};

  // ---------------- reference model: owner index -1/0/1 per instance ----------------
  int         m_own[2];
  int         m_hold[2];
  int         m_last[2];
  logic       m_s[2];
  logic       m_valid[2];
  logic [7:0] m_y[2];
  int         nx[2];

  function automatic int cap_of(int k);
    return (k == 0) ? 3 : 0;
  endfunction

  function automatic int next_owner(int o, int last, int hold, int cap, bit r0, bit r1);
    bit mine, theirs;
    if (o < 0) begin
      if (r0 && r1) return 1 - last;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    mine   = (o == 0) ? r0 : r1;
    theirs = (o == 0) ? r1 : r0;
    if (!mine) return theirs ? 1 - o : -1;
    if (theirs && hold == cap) return 1 - o;
    return o;
  endfunction

  function automatic bit has_xfer(int o, bit r0, bit r1);
    return (o == 0 && r0) || (o == 1 && r1);
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++)
      nx[k] = next_owner(m_own[k], m_last[k], m_hold[k], cap_of(k), REQ0, REQ1);
  end

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int k = 0; k < 2; k++) begin
        m_own[k]   <= -1;
        m_hold[k]  <= 0;
        m_last[k]  <= 1;
        m_s[k]     <= 1'b0;
        m_valid[k] <= 1'b0;
        m_y[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (has_xfer(m_own[k], REQ0, REQ1)) begin
          m_y[k]     <= (m_own[k] == 1) ? D1 : D0;
          m_valid[k] <= 1'b1;
        end else begin
          m_valid[k] <= 1'b0;
        end
        if (nx[k] >= 0 && nx[k] != m_own[k]) begin
          m_hold[k] <= 0;
          m_last[k] <= nx[k];
          m_s[k]    <= (nx[k] == 1);
        end else if (has_xfer(m_own[k], REQ0, REQ1) && m_hold[k] < cap_of(k)) begin
          m_hold[k] <= m_hold[k] + 1;
        end
        m_own[k] <= nx[k];
      end
    end
  end

  function automatic logic [12:0] expv(int k);
    return {m_own[k] == 0, m_own[k] == 1, m_s[k], m_own[k] >= 0, m_valid[k], m_y[k]};
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    RESETN = 1'b0;
    #1;
    RESETN = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    REQ0 = 1'b1; REQ1 = 1'b0; D0 = 8'd10; D1 = 8'd0;
    #3 RESETN = 1'b0;
    #1;
    total += 2;
    if (obs_a !== 13'h0) begin bad++; $display("FAIL reset_async_a: got %h want %h", obs_a, 13'h0); end
    if (obs_b !== 13'h0) begin bad++; $display("FAIL reset_async_b: got %h want %h", obs_b, 13'h0); end
    @(negedge CLK);
    total++;
    if (obs_a !== 13'h0) begin bad++; $display("FAIL reset_held: got %h want %h", obs_a, 13'h0); end
    RESETN = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      logic [12:0] want;
      @(negedge CLK);
      want = (i == 1) ? {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0} : {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10};
      total += 3;
      if (obs_a !== want) begin bad++; $display("FAIL reset_first_grant c%0d: got %h want %h", i, obs_a, want); end
      if (obs_a !== expv(0)) begin bad++; $display("FAIL reset_model_a c%0d: got %h want %h", i, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin bad++; $display("FAIL reset_model_b c%0d: got %h want %h", i, obs_b, expv(1)); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'd10; D1 = 8'd20;
    for (int i = 0; i < 16; i++) begin
      bit g0a, g0b;
      @(negedge CLK);
      g0a = ((i / 4) % 2) == 0;
      g0b = (i % 2) == 0;
      total += 4;
      if (A_GNT0 !== g0a || A_GNT1 !== !g0a) begin
        bad++; $display("FAIL rr_hold4 c%0d: got g0=%b g1=%b want g0=%b", i, A_GNT0, A_GNT1, g0a);
      end
      if (B_GNT0 !== g0b || B_GNT1 !== !g0b) begin
        bad++; $display("FAIL rr_hold1 c%0d: got g0=%b g1=%b want g0=%b", i, B_GNT0, B_GNT1, g0b);
      end
      if (obs_a !== expv(0)) begin bad++; $display("FAIL rr_model_a c%0d: got %h want %h", i, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin bad++; $display("FAIL rr_model_b c%0d: got %h want %h", i, obs_b, expv(1)); end
      if (i >= 1) begin
        logic [7:0] wy;
        wy = (((i - 1) / 4) % 2 == 0) ? 8'd10 : 8'd20;
        total++;
        if (A_VALID !== 1'b1 || A_Y !== wy) begin
          bad++; $display("FAIL rr_data c%0d: got v=%b y=%0d want v=1 y=%0d", i, A_VALID, A_Y, wy);
        end
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    REQ0 = 1'b1; D0 = 8'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total += 2;
      if (obs_a !== expv(0)) begin bad++; $display("FAIL rel_model_a c%0d: got %h want %h", i, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin bad++; $display("FAIL rel_model_b c%0d: got %h want %h", i, obs_b, expv(1)); end
    end
    REQ0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [12:0] want;
      @(negedge CLK);
      want = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10};
      total += 3;
      if (obs_a !== want) begin bad++; $display("FAIL release_idle_a c%0d: got %h want %h", i, obs_a, want); end
      if (obs_b !== want) begin bad++; $display("FAIL release_idle_b c%0d: got %h want %h", i, obs_b, want); end
      if (obs_a !== expv(0)) begin bad++; $display("FAIL rel_model2_a c%0d: got %h want %h", i, obs_a, expv(0)); end
    end
  endtask

  task automatic test_handover();
    do_reset();
    REQ1 = 1'b1; D0 = 8'd10; D1 = 8'd20;
    for (int j = 1; j <= 6; j++) begin
      @(negedge CLK);
      total += 2;
      if (obs_a !== expv(0)) begin bad++; $display("FAIL ho_model_a s%0d: got %h want %h", j, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin bad++; $display("FAIL ho_model_b s%0d: got %h want %h", j, obs_b, expv(1)); end
      if (j == 3) begin
        total++;
        if (A_GNT0 !== 1'b1 || A_GNT1 !== 1'b0 || A_S !== 1'b0) begin
          bad++; $display("FAIL handover_direct: got g0=%b g1=%b s=%b want 1 0 0", A_GNT0, A_GNT1, A_S);
        end
      end
      if (j == 5) begin
        total++;
        if (A_GNT1 !== 1'b1 || A_S !== 1'b1) begin
          bad++; $display("FAIL handover_tie: got g1=%b s=%b want 1 1", A_GNT1, A_S);
        end
      end
      case (j)
        1: REQ0 = 1'b1;
        2: REQ1 = 1'b0;
        3: REQ0 = 1'b0;
        4: begin REQ0 = 1'b1; REQ1 = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    REQ1 = 1'b1; D1 = 8'd20; D0 = 8'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++;
      if (obs_a !== expv(0)) begin bad++; $display("FAIL ar_model_a c%0d: got %h want %h", i, obs_a, expv(0)); end
    end
    total++;
    if (obs_a !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd20}) begin
      bad++; $display("FAIL ar_pre_own1: got %h want %h", obs_a, {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd20});
    end
    @(posedge CLK);
    #2 RESETN = 1'b0;
    #1;
    total += 2;
    if (obs_a !== 13'h0) begin bad++; $display("FAIL ar_midcycle_a: got %h want %h", obs_a, 13'h0); end
    if (obs_b !== 13'h0) begin bad++; $display("FAIL ar_midcycle_b: got %h want %h", obs_b, 13'h0); end
    #1 RESETN = 1'b1;
    REQ0 = 1'b1; REQ1 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      total += 2;
      if (obs_a !== expv(0)) begin bad++; $display("FAIL ar_model2_a c%0d: got %h want %h", j, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin bad++; $display("FAIL ar_model2_b c%0d: got %h want %h", j, obs_b, expv(1)); end
      if (j == 1) begin
        total++;
        if (A_GNT0 !== 1'b1 || B_GNT0 !== 1'b1) begin
          bad++; $display("FAIL ar_tie_to_0: got a=%b b=%b want 1 1", A_GNT0, B_GNT0);
        end
      end
    end
  endtask

  task automatic test_data_change();
    do_reset();
    REQ0 = 1'b1; D0 = 8'd10; D1 = 8'd20;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      total++;
      if (obs_a !== expv(0)) begin bad++; $display("FAIL dc_model_a c%0d: got %h want %h", i, obs_a, expv(0)); end
      if (i == 2) D0 = 8'd4;
    end
    total++;
    if (A_Y !== 8'd4 || B_Y !== 8'd4 || A_VALID !== 1'b1) begin
      bad++; $display("FAIL data_change: got ya=%0d yb=%0d v=%b want 4 4 1", A_Y, B_Y, A_VALID);
    end
    REQ1 = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK);
      total += 2;
      if (B_GNT1 !== ((j % 2) == 0) || B_GNT0 !== ((j % 2) == 1)) begin
        bad++; $display("FAIL alt_hold1 c%0d: got g0=%b g1=%b want g1=%b", j, B_GNT0, B_GNT1, (j % 2) == 0);
      end
      if (obs_b !== expv(1)) begin bad++; $display("FAIL dc_model_b c%0d: got %h want %h", j, obs_b, expv(1)); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      total += 2;
      if (obs_a !== expv(0)) begin bad++; $display("FAIL rand_a c%0d: got %h want %h", i, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin bad++; $display("FAIL rand_b c%0d: got %h want %h", i, obs_b, expv(1)); end
      REQ0 = ($urandom_range(0, 3) != 0);
      REQ1 = ($urandom_range(0, 3) != 0);
      D0 = 8'($urandom);
      D1 = 8'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        RESETN = 1'b0;
        #1;
        RESETN = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_release();
    test_handover();
    test_async_reset();
    test_data_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
